lpc_fifo_bridge: RTL

//  Data provider sitting directly downstream of lpc_periph: consumes its lpc_data_wr/lpc_data_req

---
 rtl/lpc_fifo_bridge_pkg.sv | 49 ++++
 rtl/lpc_fifo_bridge_sync_fifo.sv | 69 ++++++
 rtl/lpc_fifo_bridge.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lpc_fifo_bridge_pkg.sv
// ============================================================================
// Module : lpc_fifo_bridge_pkg
// Brief  : Register map, STATUS bit layout and FSM encoding for lpc_fifo_bridge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lpc_fifo_bridge_pkg;

    localparam int unsigned c_data_w = 8;

    // Register offsets relative to BASE_ADDR
    localparam logic c_reg_data   = 1'b0;
    localparam logic c_reg_status = 1'b1;

    // STATUS bit positions; tx_ovf/rx_unf positions double as W1C clear bits
    localparam int unsigned c_stat_rx_nonempty = 0;
    localparam int unsigned c_stat_tx_full     = 1;
    localparam int unsigned c_stat_tx_ovf      = 2;
    localparam int unsigned c_stat_rx_unf      = 3;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wr_ack   = 2'd1;
    localparam logic [1:0] c_st_rd_drive = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = c_st_idle,
        ST_WR_ACK   = c_st_wr_ack,
        ST_RD_DRIVE = c_st_rd_drive
    } lpc_fb_state_e;

    function automatic logic [c_data_w-1:0] status_byte(
        input logic rx_unf,
        input logic tx_ovf,
        input logic tx_full,
        input logic rx_nonempty
    );
        logic [c_data_w-1:0] s;
        s                     = '0;
        s[c_stat_rx_nonempty] = rx_nonempty;
        s[c_stat_tx_full]     = tx_full;
        s[c_stat_tx_ovf]      = tx_ovf;
        s[c_stat_rx_unf]      = rx_unf;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lpc_fifo_bridge_sync_fifo.sv
// ============================================================================
// Module : lpc_sync_fifo
// Brief  : Single-clock FIFO with show-ahead head; a push while full is taken
//          when a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lpc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned c_aw = $clog2(DEPTH);
    localparam int unsigned c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == c_cw'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are power-of-two wide, so wrap is implicit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/lpc_fifo_bridge.sv
// ============================================================================
// Module : lpc_fifo_bridge
// Brief  : 2-byte LPC I/O window (DATA, STATUS) bridging host writes into a TX
//          FIFO and an RX FIFO into host reads. Optional irq_o port and logic
//          enabled by defining LPC_FIFO_BRIDGE_IRQ_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lpc_fifo_bridge
    import lpc_fifo_bridge_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0CA0,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    inout  wire  [c_data_w-1:0] lpc_data_io,
    input  logic [15:0]         lpc_addr_i,
    input  logic                lpc_data_wr,
    output logic                lpc_wr_done,
    input  logic                lpc_data_req,
    output logic                lpc_data_rd,
    output logic [c_data_w-1:0] tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    input  logic [c_data_w-1:0] rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o
`ifdef LPC_FIFO_BRIDGE_IRQ_EN
    ,
    output logic                irq_o
`endif
);

    lpc_fb_state_e       r_state;
    logic                r_wr_done;
    logic                r_data_rd;
    logic                r_tx_ovf;
    logic                r_rx_unf;
    logic                r_rd_pop;
    logic [c_data_w-1:0] r_rd_data;

    logic [15:0]         w_off;
    logic                w_hit;
    logic                w_sel_data;
    logic                w_sel_status;
    logic                w_wr_start;
    logic                w_rd_start;
    logic                w_tx_full;
    logic                w_tx_empty;
    logic                w_rx_full;
    logic                w_rx_empty;
    logic [c_data_w-1:0] w_rx_head;
    logic                w_tx_push;
    logic                w_tx_pop;
    logic                w_tx_drop;
    logic                w_rx_push;
    logic                w_rx_pop;
    logic [c_data_w-1:0] w_status;
    logic [c_data_w-1:0] w_rd_mux;

    assign w_off        = lpc_addr_i - BASE_ADDR;
    assign w_hit        = (w_off[15:1] == '0);
    assign w_sel_data   = w_hit & (w_off[0] == c_reg_data);
    assign w_sel_status = w_hit & (w_off[0] == c_reg_status);

    // Write wins when both strobes are seen in IDLE
    assign w_wr_start = (r_state == ST_IDLE) & lpc_data_wr;
    assign w_rd_start = (r_state == ST_IDLE) & ~lpc_data_wr & lpc_data_req;

    assign w_tx_pop  = tx_ready_i & ~w_tx_empty;
    assign w_tx_push = w_wr_start & w_sel_data & (~w_tx_full | w_tx_pop);
    assign w_tx_drop = w_wr_start & w_sel_data & w_tx_full & ~w_tx_pop;

    // RX pop only once the host has actually been handed the byte
    assign w_rx_pop  = (r_state == ST_RD_DRIVE) & ~lpc_data_req & r_rd_pop & r_data_rd;
    assign w_rx_push = rx_valid_i & (~w_rx_full | w_rx_pop);

    assign w_status = status_byte(r_rx_unf, r_tx_ovf, w_tx_full, ~w_rx_empty);

    always_comb begin
        w_rd_mux = 8'hFF;
        if (w_sel_data) begin
            w_rd_mux = w_rx_empty ? 8'h00 : w_rx_head;
        end else if (w_sel_status) begin
            w_rd_mux = w_status;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_wr_done <= 1'b0;
            r_data_rd <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_rx_unf  <= 1'b0;
            r_rd_pop  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_start) begin
                        r_state   <= ST_WR_ACK;
                        r_wr_done <= 1'b1;
                        if (w_tx_drop) begin
                            r_tx_ovf <= 1'b1;
                        end
                        if (w_sel_status) begin
                            if (lpc_data_io[c_stat_tx_ovf]) r_tx_ovf <= 1'b0;
                            if (lpc_data_io[c_stat_rx_unf]) r_rx_unf <= 1'b0;
                        end
                    end else if (w_rd_start) begin
                        r_state   <= ST_RD_DRIVE;
                        r_data_rd <= 1'b1;
                        r_rd_data <= w_rd_mux;
                        r_rd_pop  <= w_sel_data & ~w_rx_empty;
                        if (w_sel_data & w_rx_empty) begin
                            r_rx_unf <= 1'b1;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (!lpc_data_wr) begin
                        r_state   <= ST_IDLE;
                        r_wr_done <= 1'b0;
                    end
                end
                ST_RD_DRIVE: begin
                    if (!lpc_data_req) begin
                        r_state   <= ST_IDLE;
                        r_data_rd <= 1'b0;
                        r_rd_pop  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign lpc_wr_done = r_wr_done;
    assign lpc_data_rd = r_data_rd;
    assign lpc_data_io = ((r_state == ST_RD_DRIVE) && r_data_rd) ? r_rd_data : {c_data_w{1'bz}};
    assign tx_valid_o  = ~w_tx_empty;
    assign rx_ready_o  = ~w_rx_full;

    lpc_sync_fifo #(
        .WIDTH (c_data_w),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_tx_push),
        .i_data  (lpc_data_io),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (tx_data_o)
    );

    lpc_sync_fifo #(
        .WIDTH (c_data_w),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_rx_push),
        .i_data  (rx_data_i),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

`ifdef LPC_FIFO_BRIDGE_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ~w_rx_empty | r_tx_ovf | r_rx_unf;
        end
    end

    assign irq_o = r_irq;
`endif

endmodule

`default_nettype wire
